// File: rtl/nn_seq_if.sv
// Handshake and datapath bundle between the layer sequencer, its RAMs, the nn_dp PEs and the front end.
interface nn_seq_if #(
    parameter int unsigned AW = 8
);
    logic          start;
    logic [AW-1:0] n_in;
    logic          busy;
    logic          done;
    logic [AW-1:0] rd_addr;
    logic [15:0]   x_rdata;
    logic [127:0]  w_rdata;
    logic          clr;
    logic [15:0]   x;
    logic [15:0]   w0, w1, w2, w3, w4, w5, w6, w7;
    logic [15:0]   z0, z1, z2, z3, z4, z5, z6, z7;
    logic [15:0]   y0, y1, y2, y3, y4, y5, y6, y7;

    modport slave (
        input  start, n_in, x_rdata, w_rdata,
        input  z0, z1, z2, z3, z4, z5, z6, z7,
        output busy, done, rd_addr, clr, x,
        output w0, w1, w2, w3, w4, w5, w6, w7,
        output y0, y1, y2, y3, y4, y5, y6, y7
    );

    modport master (
        output start, n_in, x_rdata, w_rdata,
        output z0, z1, z2, z3, z4, z5, z6, z7,
        input  busy, done, rd_addr, clr, x,
        input  w0, w1, w2, w3, w4, w5, w6, w7,
        input  y0, y1, y2, y3, y4, y5, y6, y7
    );
endinterface

// File: rtl/nn_seq.sv
// Sequencer for one 8-neuron nn_dp layer pass: clear, feed N samples/weights, drain, capture, done.
// Build option NN_SEQ_RELU_EN applies ReLU to the captured results (same timing either way).
module nn_seq #(
    parameter int unsigned AW        = 8,
    parameter int unsigned DRAIN_CYC = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    nn_seq_if.slave    bus
);
    localparam int unsigned DW = $clog2(DRAIN_CYC + 1);
    localparam int unsigned NPE = 8;
    localparam int unsigned DATW = 16;

    typedef enum logic [2:0] {S_IDLE, S_CLR, S_FEED, S_DRAIN, S_CAP} state_t;

    state_t                        state_q, state_d;
    logic [AW-1:0]                 n_q, n_d;
    logic [AW-1:0]                 rd_addr_q, rd_addr_d;
    logic [DW-1:0]                 dcnt_q, dcnt_d;
    logic                          rd_vld_q, rd_vld_d;
    logic                          busy_q, busy_d;
    logic                          done_q, done_d;
    logic                          clr_q, clr_d;
    logic [DATW-1:0]               x_q, x_d;
    logic [NPE-1:0][DATW-1:0]      w_q, w_d;
    logic [NPE-1:0][DATW-1:0]      y_q, y_d;
    logic [NPE-1:0][DATW-1:0]      z_c;

    assign z_c = {bus.z7, bus.z6, bus.z5, bus.z4, bus.z3, bus.z2, bus.z1, bus.z0};

    // Next state plus every registered output; x/w fall to zero whenever no read is in flight.
    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        rd_addr_d = '0;
        dcnt_d    = '0;
        x_d       = '0;
        w_d       = '0;
        y_d       = y_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start && !busy_q) begin
                    state_d = S_CLR;
                    n_d     = bus.n_in;
                end
            end
            S_CLR: begin
                state_d = (n_q == '0) ? S_DRAIN : S_FEED;
            end
            S_FEED: begin
                rd_addr_d = rd_addr_q + AW'(1);
                if (rd_addr_q == n_q - AW'(1)) begin
                    state_d   = S_DRAIN;
                    rd_addr_d = '0;
                end
            end
            S_DRAIN: begin
                dcnt_d = dcnt_q + DW'(1);
                if (dcnt_q == DW'(DRAIN_CYC - 1)) begin
                    state_d = S_CAP;
                    dcnt_d  = '0;
                end
            end
            S_CAP: begin
                state_d = S_IDLE;
                for (int i = 0; i < NPE; i++) begin
`ifdef NN_SEQ_RELU_EN
                    y_d[i] = z_c[i][DATW-1] ? '0 : z_c[i];
`else
                    y_d[i] = z_c[i];
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase

        rd_vld_d = (state_q == S_FEED);
        if (rd_vld_q) begin
            x_d = bus.x_rdata;
            w_d = bus.w_rdata;
        end
        clr_d  = (state_d == S_CLR);
        busy_d = (state_d != S_IDLE) || (state_q == S_CAP);
        done_d = (state_q == S_CAP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            n_q       <= '0;
            rd_addr_q <= '0;
            dcnt_q    <= '0;
            rd_vld_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            clr_q     <= 1'b0;
            x_q       <= '0;
            w_q       <= '0;
            y_q       <= '0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            rd_addr_q <= rd_addr_d;
            dcnt_q    <= dcnt_d;
            rd_vld_q  <= rd_vld_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            clr_q     <= clr_d;
            x_q       <= x_d;
            w_q       <= w_d;
            y_q       <= y_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.clr     = clr_q;
    assign bus.rd_addr = rd_addr_q;
    assign bus.x       = x_q;
    assign bus.w0      = w_q[0];
    assign bus.w1      = w_q[1];
    assign bus.w2      = w_q[2];
    assign bus.w3      = w_q[3];
    assign bus.w4      = w_q[4];
    assign bus.w5      = w_q[5];
    assign bus.w6      = w_q[6];
    assign bus.w7      = w_q[7];
    assign bus.y0      = y_q[0];
    assign bus.y1      = y_q[1];
    assign bus.y2      = y_q[2];
    assign bus.y3      = y_q[3];
    assign bus.y4      = y_q[4];
    assign bus.y5      = y_q[5];
    assign bus.y6      = y_q[6];
    assign bus.y7      = y_q[7];
endmodule

// File: tb/tb_nn_seq.sv
// Bench for nn_seq: RAM and PE models around the sequencer, per-cycle timing checks and a sum-of-products reference.
module tb_nn_seq;
    localparam int unsigned AW    = 8;
    localparam int unsigned DRAIN = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    nn_seq_if #(.AW(AW)) bus ();

    nn_seq #(.AW(AW), .DRAIN_CYC(DRAIN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0]      xm [256];
    logic [127:0]     wm [256];
    logic [127:0]     y_exp = '0;
    logic [7:0][15:0] z_m   = '0;

    function automatic logic [15:0] step(input logic [15:0] a, input logic [15:0] b);
        logic signed [31:0] p;
        p = $signed(a) * $signed(b);
        return 16'(p >>> 8);
    endfunction

    // Input and weight RAMs, one-cycle read latency
    always @(posedge clk) begin
        bus.x_rdata <= xm[bus.rd_addr];
        bus.w_rdata <= wm[bus.rd_addr];
    end

    // Free-running nn_dp PEs
    always @(posedge clk) begin
        for (int i = 0; i < 8; i++)
            z_m[i] <= bus.clr ? 16'h0000 : z_m[i] + step(bus.x, w_now() >> (16 * i));
    end

    assign bus.z0 = z_m[0];
    assign bus.z1 = z_m[1];
    assign bus.z2 = z_m[2];
    assign bus.z3 = z_m[3];
    assign bus.z4 = z_m[4];
    assign bus.z5 = z_m[5];
    assign bus.z6 = z_m[6];
    assign bus.z7 = z_m[7];

    function automatic logic [127:0] w_now();
        return {bus.w7, bus.w6, bus.w5, bus.w4, bus.w3, bus.w2, bus.w1, bus.w0};
    endfunction

    function automatic logic [127:0] y_now();
        return {bus.y7, bus.y6, bus.y5, bus.y4, bus.y3, bus.y2, bus.y1, bus.y0};
    endfunction

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Layer result: per-neuron sum over N steps of truncated Q8.8 products, then f()
    function automatic logic [127:0] ref_y(input int n);
        logic [127:0] r;
        logic [15:0]  acc;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            acc = '0;
            for (int k = 0; k < n; k++)
                acc = acc + step(xm[k], wm[k][16*i +: 16]);
`ifdef NN_SEQ_RELU_EN
            if (acc[15]) acc = '0;
`endif
            r[16*i +: 16] = acc;
        end
        return r;
    endfunction

    task automatic fill_rand(input int n);
        for (int k = 0; k < n; k++) begin
            xm[k] = 16'($urandom);
            wm[k] = {$urandom, $urandom, $urandom, $urandom};
        end
    endtask

    task automatic fill_t1();
        xm[0] = 16'h0100;
        xm[1] = 16'h0200;
        xm[2] = 16'hFF00;
        for (int k = 0; k < 3; k++) begin
            wm[k] = {$urandom, $urandom, $urandom, $urandom};
            wm[k][15:0]  = 16'h0100;
            wm[k][31:16] = 16'h0080;
            wm[k][47:32] = 16'hFF00;
        end
    endtask

    task automatic check_t1_y();
        check("t1_y0", 128'(bus.y0), 128'(16'h0200));
        check("t1_y1", 128'(bus.y1), 128'(16'h0100));
`ifdef NN_SEQ_RELU_EN
        check("t1_y2", 128'(bus.y2), 128'(16'h0000));
`else
        check("t1_y2", 128'(bus.y2), 128'(16'hFE00));
`endif
    endtask

    // One pass from start (cycle S) to the done cycle S+N+DRAIN+3; optionally pokes start
    // while busy and in the done cycle, or pulls reset at relative cycle abort_at.
    task automatic run_pass(input int n, input bit poke, input int abort_at);
        int           t;
        bit           aborted;
        logic [127:0] y_new;
        t       = n + int'(DRAIN) + 3;
        aborted = 1'b0;
        @(negedge clk);
        check("idle_busy", 128'(bus.busy), 128'(0));
        check("idle_done", 128'(bus.done), 128'(0));
        check("idle_clr",  128'(bus.clr),  128'(0));
        y_new     = ref_y(n);
        bus.start = 1'b1;
        bus.n_in  = AW'(n);
        for (int j = 1; j <= t && !aborted; j++) begin
            @(negedge clk);
            bus.start = poke && (j == 2 || j == t);
            bus.n_in  = AW'($urandom);
            if (j == abort_at) begin
                rst_n = 1'b0;
                #1;
                y_exp = '0;
                check("rst_busy", 128'(bus.busy),    128'(0));
                check("rst_done", 128'(bus.done),    128'(0));
                check("rst_clr",  128'(bus.clr),     128'(0));
                check("rst_addr", 128'(bus.rd_addr), 128'(0));
                check("rst_x",    128'(bus.x),       128'(0));
                check("rst_w",    w_now(),           128'(0));
                check("rst_y",    y_now(),           y_exp);
                bus.start = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("rst_hold_busy", 128'(bus.busy), 128'(0));
                    check("rst_hold_done", 128'(bus.done), 128'(0));
                end
                rst_n   = 1'b1;
                aborted = 1'b1;
            end else begin
                if (j == t) y_exp = y_new;
                check("busy",    128'(bus.busy), 128'(1));
                check("done",    128'(bus.done), 128'(j == t));
                check("clr",     128'(bus.clr),  128'(j == 1));
                check("rd_addr", 128'(bus.rd_addr), (j >= 2 && j - 2 < n) ? 128'(j - 2) : 128'(0));
                check("x",       128'(bus.x),    (j >= 4 && j - 4 < n) ? 128'(xm[j-4]) : 128'(0));
                check("w",       w_now(),        (j >= 4 && j - 4 < n) ? wm[j-4] : 128'(0));
                check("y",       y_now(),        y_exp);
            end
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.n_in  = '0;
        for (int k = 0; k < 256; k++) begin
            xm[k] = '0;
            wm[k] = '0;
        end
        repeat (2) @(negedge clk);
        check("reset_busy", 128'(bus.busy),    128'(0));
        check("reset_done", 128'(bus.done),    128'(0));
        check("reset_clr",  128'(bus.clr),     128'(0));
        check("reset_addr", 128'(bus.rd_addr), 128'(0));
        check("reset_x",    128'(bus.x),       128'(0));
        check("reset_w",    w_now(),           128'(0));
        check("reset_y",    y_now(),           128'(0));
        rst_n = 1'b1;

        // T1 / T2: directed N=3
        fill_t1();
        run_pass(3, 1'b0, 0);
        check_t1_y();

        // T3: N=0
        run_pass(0, 1'b0, 0);
        check("t3_y", y_now(), 128'(0));

        // T4: start ignored while busy and in the done cycle, then accepted right after
        fill_rand(5);
        run_pass(5, 1'b1, 0);
        fill_rand(7);
        run_pass(7, 1'b0, 0);

        // T5: reset during FEED of a long pass, then a clean T1 pass
        fill_rand(200);
        run_pass(200, 1'b0, 50);
        fill_t1();
        run_pass(3, 1'b0, 0);
        check_t1_y();

        // T6: N=255, tiny products truncate to zero every step
        for (int k = 0; k < 255; k++) begin
            xm[k] = 16'h0001;
            wm[k] = {8{16'h0001}};
        end
        run_pass(255, 1'b0, 0);
        check("t6_y", y_now(), 128'(0));

        // Randomized passes
        for (int r = 0; r < 8; r++) begin
            int n;
            n = int'($urandom_range(1, 40));
            fill_rand(n);
            run_pass(n, r[0], 0);
        end

        @(negedge clk);
        check("final_busy", 128'(bus.busy), 128'(0));
        check("final_done", 128'(bus.done), 128'(0));
        check("final_y",    y_now(),        y_exp);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
